// File: rtl/param_line_buffer.sv
// Raster line buffer: presents a vertical column of ROWS pixels per accepted beat,
// with position tracking, line/frame completion and a selectable top-border policy.
module param_line_buffer #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ROWS     = 3,
  parameter int PAD_MODE = 0
) (
  input  logic                      line_clk,
  input  logic                      s_rst,
  input  logic                      in_vsync,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         din,
  output logic                      out_valid,
  output logic [ROWS*DATA_W-1:0]    taps,
  output logic [$clog2(IMG_W)-1:0]  out_col,
  output logic [$clog2(IMG_H)-1:0]  out_row,
  output logic                      line_done,
  output logic                      frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(ROWS - 1);

  logic [DATA_W-1:0]      mem_q [ROWS-1][IMG_W];
  logic [CW-1:0]          col_q, col_d, col_eff;
  logic [RW-1:0]          row_q, row_d, row_eff;
  logic [FW-1:0]          fill_q, fill_d, fill_eff;
  logic                   last_col, last_row, suppress;
  logic [DATA_W-1:0]      col_px [ROWS];
  logic [ROWS*DATA_W-1:0] taps_d;

  // Position/priming next state; a frame-start pulse zeroes the counters before this beat uses them.
  always_comb begin
    col_eff  = in_vsync ? '0 : col_q;
    row_eff  = in_vsync ? '0 : row_q;
    fill_eff = in_vsync ? '0 : fill_q;
    last_col = (col_eff == COL_LAST);
    last_row = (row_eff == ROW_LAST);
    suppress = (PAD_MODE == 0) && (fill_eff != FILL_MAX);
    col_d    = col_eff;
    row_d    = row_eff;
    fill_d   = fill_eff;
    if (in_valid) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          fill_d = '0;
        end else begin
          row_d  = row_eff + 1'b1;
          fill_d = (fill_eff == FILL_MAX) ? fill_eff : fill_eff + 1'b1;
        end
      end else begin
        col_d = col_eff + 1'b1;
      end
    end else begin
      col_d = col_eff;
    end
  end

  // Column gather and top-border masking; unprimed taps never expose old-frame memory.
  always_comb begin
    col_px[0] = din;
    for (int k = 1; k < ROWS; k++) begin
      col_px[k] = mem_q[k-1][col_eff];
    end
    taps_d = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (FW'(k) <= fill_eff) begin
        taps_d[k*DATA_W +: DATA_W] = col_px[k];
      end else if (PAD_MODE == 2) begin
        taps_d[k*DATA_W +: DATA_W] = col_px[fill_eff];
      end else begin
        taps_d[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // Counters and registered outputs; outputs hold across gaps with out_valid low.
  always_ff @(posedge line_clk) begin
    if (s_rst) begin
      col_q      <= '0;
      row_q      <= '0;
      fill_q     <= '0;
      out_valid  <= 1'b0;
      taps       <= '0;
      out_col    <= '0;
      out_row    <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      fill_q <= fill_d;
      if (in_valid) begin
        out_valid  <= !suppress;
        taps       <= taps_d;
        out_col    <= col_eff;
        out_row    <= row_eff;
        line_done  <= last_col;
        frame_done <= last_col && last_row;
      end else begin
        out_valid  <= 1'b0;
        line_done  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Line-memory cascade: read-before-write, each memory inherits what the one above held here.
  always_ff @(posedge line_clk) begin
    if (!s_rst && in_valid) begin
      mem_q[0][col_eff] <= din;
      for (int j = 1; j < ROWS-1; j++) begin
        mem_q[j][col_eff] <= mem_q[j-1][col_eff];
      end
    end
  end
endmodule
